// File: rtl/decode_hazard_ctrl.sv
// Issue controller between decode and execute. It tracks pending register
// writes and in-flight instructions, stalls decode on RAW/WAW hazards,
// back-pressure or a full pipeline, and runs ECALL/FENCE alone through an
// empty pipeline.
module decode_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [4:0]          dec_r1,
  input  logic [4:0]          dec_r2,
  input  logic                dec_uses_r2,
  input  logic [4:0]          dec_dst,
  input  logic                dec_serialize,
  input  logic                next_stage_ready,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [4:0]          wb_dst,
  output logic                issue,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    inflight,
  output logic                serial_busy,
  output logic                err_retire
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_SERIAL = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]          state, state_nxt;
  logic                hazard;
  logic                empty;
  logic [NUM_REGS-1:0] pending_nxt;

  assign empty       = (inflight == '0);
  assign serial_busy = (state != S_RUN);

  // Hazard check uses the registered scoreboard only; a retire in the same
  // cycle does not unblock the instruction until the next cycle.
  always_comb begin
    hazard = 1'b0;
    if (dec_r1 != 5'd0 && pending_mask[dec_r1])                 hazard = 1'b1;
    if (dec_uses_r2 && dec_r2 != 5'd0 && pending_mask[dec_r2])  hazard = 1'b1;
    if (dec_dst != 5'd0 && pending_mask[dec_dst])               hazard = 1'b1;
  end

  // Issue decision and next serialization state.
  always_comb begin
    issue     = 1'b0;
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (dec_valid && dec_serialize && !flush) begin
          if (empty && next_stage_ready) begin
            issue     = 1'b1;
            state_nxt = S_SERIAL;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else begin
          issue = dec_valid && !dec_serialize && !flush && next_stage_ready &&
                  !hazard && (inflight < MAX_CNT);
        end
      end
      S_DRAIN: begin
        if (flush) begin
          state_nxt = S_RUN;
        end else if (dec_valid && empty && next_stage_ready) begin
          issue     = 1'b1;
          state_nxt = S_SERIAL;
        end
      end
      S_SERIAL: begin
        if (wb_valid && inflight == ONE) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
    if (!reset) begin
      issue     = 1'b0;
      state_nxt = S_RUN;
    end
  end

  assign stall = reset && dec_valid && !issue && !flush;

  // Scoreboard next value: retire clears, issue sets (set wins); x0 never tracked.
  always_comb begin
    pending_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      pending_nxt[i] = (pending_mask[i] && !(wb_valid && wb_dst == 5'(i))) ||
                       (issue && dec_dst == 5'(i));
    end
  end

  // State, scoreboard, in-flight counter and sticky retire error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_RUN;
      pending_mask <= '0;
      inflight     <= '0;
      err_retire   <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending_mask <= pending_nxt;
      if (issue && !wb_valid)
        inflight <= inflight + ONE;
      else if (wb_valid && !issue && !empty)
        inflight <= inflight - ONE;
      if (wb_valid && empty)
        err_retire <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: a behavioural model is compared to
// the DUT every cycle, and literal expectations pin key test-plan points.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_uses_r2, dec_serialize, next_stage_ready, flush, wb_valid;
  logic [4:0]  dec_r1, dec_r2, dec_dst, wb_dst;
  logic        issue, stall, serial_busy, err_retire;
  logic [31:0] pending_mask;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.NUM_REGS(32), .MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_r1(dec_r1), .dec_r2(dec_r2),
    .dec_uses_r2(dec_uses_r2), .dec_dst(dec_dst), .dec_serialize(dec_serialize),
    .next_stage_ready(next_stage_ready), .flush(flush), .wb_valid(wb_valid),
    .wb_dst(wb_dst), .issue(issue), .stall(stall), .pending_mask(pending_mask),
    .inflight(inflight), .serial_busy(serial_busy), .err_retire(err_retire)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 normal issue, 1 waiting for pipeline to empty, 2 serial op alone
  bit pend[32];
  int cnt  = 0;
  int mode = 0;
  bit err  = 0;

  function automatic bit busy_reg(input logic [4:0] r);
    return (r != 0) && pend[r];
  endfunction

  always @(negedge clk) begin
    if (go) begin
      bit e_issue, haz;
      logic [31:0] e_mask;
      haz = busy_reg(dec_r1) || (dec_uses_r2 && busy_reg(dec_r2)) || busy_reg(dec_dst);
      e_issue = 1'b0;
      if (reset) begin
        if (mode == 0) begin
          if (dec_valid && dec_serialize && !flush) e_issue = (cnt == 0) && next_stage_ready;
          else e_issue = dec_valid && !dec_serialize && !flush && next_stage_ready && !haz && cnt < 4;
        end else if (mode == 1) begin
          e_issue = dec_valid && !flush && cnt == 0 && next_stage_ready;
        end
      end
      e_mask = '0;
      for (int i = 0; i < 32; i++) e_mask[i] = pend[i];
      chk("issue", 32'(issue), 32'(e_issue));
      chk("stall", 32'(stall), 32'(reset && dec_valid && !e_issue && !flush));
      chk("pending_mask", pending_mask, e_mask);
      chk("inflight", 32'(inflight), 32'(cnt));
      chk("serial_busy", 32'(serial_busy), 32'(mode != 0));
      chk("err_retire", 32'(err_retire), 32'(err));
      // advance model to what the coming rising edge produces
      if (!reset) begin
        foreach (pend[i]) pend[i] = 1'b0;
        cnt = 0; mode = 0; err = 0;
      end else begin
        if (mode == 0 && dec_valid && dec_serialize && !flush) mode = e_issue ? 2 : 1;
        else if (mode == 1 && flush) mode = 0;
        else if (mode == 1 && e_issue) mode = 2;
        else if (mode == 2 && wb_valid && cnt == 1) mode = 0;
        if (wb_valid && cnt == 0) err = 1;
        if (e_issue && !wb_valid) cnt++;
        else if (wb_valid && !e_issue && cnt > 0) cnt--;
        if (wb_valid && wb_dst != 0) pend[wb_dst] = 1'b0;
        if (e_issue && dec_dst != 0) pend[dec_dst] = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_r1 = 0; dec_r2 = 0; dec_uses_r2 = 0; dec_dst = 0;
    dec_serialize = 0; flush = 0; wb_valid = 0; wb_dst = 0; next_stage_ready = 1;
  endtask

  task automatic instr(input logic [4:0] r1, input logic [4:0] r2, input bit u2,
                       input logic [4:0] dst, input bit ser);
    dec_valid = 1; dec_r1 = r1; dec_r2 = r2; dec_uses_r2 = u2; dec_dst = dst;
    dec_serialize = ser;
  endtask

  task automatic retire(input logic [4:0] d);
    wb_valid = 1; wb_dst = d;
  endtask

  task automatic nodec();
    dec_valid = 0; dec_serialize = 0;
  endtask

  initial begin
    idle();
    reset = 0;
    tick(); go = 1'b1;
    tick();
    #1;
    chk("reset_mask", pending_mask, 32'h0);
    chk("reset_inflight", 32'(inflight), 32'd0);
    reset = 1;
    tick();

    // RAW
    instr(0, 0, 0, 5, 0); #1 chk("raw_first_issue", 32'(issue), 1); tick();
    instr(5, 0, 0, 9, 0); #1 chk("raw_stall", 32'(stall), 1);
    chk("raw_mask", pending_mask, 32'h20); tick();
    retire(5); #1 chk("raw_no_bypass", 32'(issue), 0); tick();
    wb_valid = 0; #1 chk("raw_after_retire", 32'(issue), 1); tick();
    nodec(); retire(9); tick(); wb_valid = 0;

    // WAW and x0
    instr(0, 0, 0, 7, 0); tick();
    instr(0, 0, 1, 7, 0); #1 chk("waw_stall", 32'(stall), 1); tick();
    instr(0, 0, 0, 0, 0); #1 chk("x0_issue", 32'(issue), 1); tick();
    chk("x0_mask", pending_mask, 32'h80);
    nodec(); retire(7); tick(); retire(0); tick(); wb_valid = 0;

    // Capacity
    for (int d = 1; d <= 3; d++) begin instr(0, 0, 0, 5'(d), 0); tick(); end
    instr(0, 0, 0, 4, 0); retire(1); tick();
    chk("cap_issue_retire_same", 32'(inflight), 3);
    wb_valid = 0; instr(0, 0, 0, 5, 0); tick();
    chk("cap_full", 32'(inflight), 4);
    instr(0, 0, 0, 6, 0); #1 chk("cap_fifth_stall", 32'(stall), 1); tick();
    retire(2); #1 chk("cap_retire_same_cycle", 32'(issue), 0); tick();
    wb_valid = 0; #1 chk("cap_fifth_issue", 32'(issue), 1); tick();
    chk("cap_still_full", 32'(inflight), 4);
    nodec();
    for (int d = 3; d <= 6; d++) begin retire(5'(d)); tick(); end
    wb_valid = 0;

    // ECALL serialize
    instr(0, 0, 0, 1, 0); tick(); instr(0, 0, 0, 2, 0); tick();
    instr(0, 0, 0, 0, 1); #1 chk("ecall_no_issue", 32'(issue), 0); tick();
    chk("ecall_drain_busy", 32'(serial_busy), 1);
    retire(1); tick();
    retire(2); #1 chk("ecall_wait_empty", 32'(issue), 0); tick();
    wb_valid = 0; #1 chk("ecall_issue", 32'(issue), 1); tick();
    instr(0, 0, 0, 3, 0); #1 chk("serial_blocks", 32'(issue), 0);
    retire(0); tick();
    wb_valid = 0; #1 chk("serial_resume", 32'(issue), 1); tick();
    chk("serial_done", 32'(serial_busy), 0);
    nodec(); retire(3); tick(); wb_valid = 0;

    // Back-pressure and flush
    next_stage_ready = 0; instr(0, 0, 0, 4, 0);
    #1 chk("bp_stall", 32'(stall), 1);
    flush = 1; #1 chk("flush_no_stall", 32'(stall), 0); tick();
    flush = 0; next_stage_ready = 1; instr(0, 0, 0, 5, 0); tick();
    instr(0, 0, 0, 0, 1); tick();
    chk("drain_entered", 32'(serial_busy), 1);
    flush = 1; tick();
    chk("flush_exits_drain", 32'(serial_busy), 0);
    flush = 0; nodec(); retire(5); tick(); wb_valid = 0;

    // Error and reset in SERIAL
    retire(3); tick(); wb_valid = 0;
    chk("err_set", 32'(err_retire), 1);
    chk("err_inflight_zero", 32'(inflight), 0);
    tick(); chk("err_sticky", 32'(err_retire), 1);
    instr(0, 0, 0, 7, 1); tick(); nodec();
    chk("serial_mask", pending_mask, 32'h80);
    chk("serial_state", 32'(serial_busy), 1);
    reset = 0; tick();
    chk("rst_mask", pending_mask, 32'h0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_state", 32'(serial_busy), 0);
    chk("rst_err", 32'(err_retire), 0);
    reset = 1; instr(0, 0, 0, 8, 0); #1 chk("post_rst_issue", 32'(issue), 1); tick();
    idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
